// File: rtl/rule110_readout_if.sv
// Byte-stream valid/ready channel carrying the rule-110 row dump to the pin mux.
interface rule110_readout_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/rule110_readout.sv
// Snapshots one rule-110 generation on request and streams it out byte by byte.
// Optional trailing popcount byte enabled by RULE110_READOUT_POPCOUNT_EN.
module rule110_readout #(
  parameter int unsigned CELLS = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CELLS-1:0]      cells,
  input  logic                  cells_valid,
  input  logic                  start,
  rule110_readout_if.master     out,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned NBYTES = CELLS / 8;
  localparam int unsigned IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

`ifdef RULE110_READOUT_POPCOUNT_EN
  typedef enum logic [1:0] {IDLE, ARM, SEND, POP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARM, SEND} state_t;
`endif

  state_t                   state_q, state_d;
  logic [NBYTES-1:0][7:0]   snap_q, snap_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic                     overrun_q, overrun_d;
  logic                     capture;
  logic                     xfer;

  assign capture = (state_q == ARM) && cells_valid;
  assign xfer    = out.out_valid && out.out_ready;

`ifdef RULE110_READOUT_POPCOUNT_EN
  logic [7:0] pop_q;
  logic [8:0] pop_sum;
  logic [7:0] pop_sat;

  always_comb begin
    pop_sum = '0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      pop_sum = pop_sum + 9'(cells[i]);
    end
    // 256 live cells does not fit a byte; clamp to 255.
    pop_sat = pop_sum[8] ? 8'hFF : pop_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_q <= '0;
    end else if (capture) begin
      pop_q <= pop_sat;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ARM;
          overrun_d = 1'b0;
        end
      end
      ARM: begin
        idx_d = '0;
        if (cells_valid) begin
          snap_d  = cells;
          state_d = SEND;
        end
      end
      SEND: begin
        if (cells_valid) begin
          overrun_d = 1'b1;
        end
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
`ifdef RULE110_READOUT_POPCOUNT_EN
            state_d = POP;
`else
            state_d = IDLE;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef RULE110_READOUT_POPCOUNT_EN
      POP: begin
        if (cells_valid) begin
          overrun_d = 1'b1;
        end
        if (xfer) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  always_comb begin
    out.out_valid = 1'b0;
    out.out_data  = '0;
    unique case (state_q)
      SEND: begin
        out.out_valid = 1'b1;
        out.out_data  = snap_q[idx_q];
      end
`ifdef RULE110_READOUT_POPCOUNT_EN
      POP: begin
        out.out_valid = 1'b1;
        out.out_data  = pop_q;
      end
`endif
      default: ;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

endmodule
